// File: rtl/itrx_aib_phy_sync_filter_pkg.sv
// Shared types for the AIB sync/debounce filter: FSM state encoding and run-counter width.
package itrx_aib_phy_sync_filter_pkg;

    typedef enum logic [1:0] {
        ST_LO  = 2'b00,
        CHK_HI = 2'b01,
        ST_HI  = 2'b11,
        CHK_LO = 2'b10
    } state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/itrx_aib_phy_bit_sync.sv
// Multi-flop level synchronizer; latency NUM_FLOPS cycles; no backpressure.
module itrx_aib_phy_bit_sync #(
    parameter int NUM_FLOPS = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [NUM_FLOPS-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NUM_FLOPS-2:0], i_d};
        end
    end

    assign o_q = r_sync[NUM_FLOPS-1];

endmodule

// File: rtl/itrx_aib_phy_sync_filter.sv
// Synchronize + debounce a single async level; commit after NUM_FLOPS+DEBOUNCE_CYCLES edges.
// Emits registered rise/fall pulses and a saturating count of rejected excursions; no backpressure.
module itrx_aib_phy_sync_filter
    import itrx_aib_phy_sync_filter_pkg::*;
#(
    parameter int NUM_FLOPS       = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din,
    input  logic                glitch_clr,
    output logic                dout,
    output logic                rise_pls,
    output logic                fall_pls,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam logic [CNT_W-1:0]    LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    LP_ONE  = CNT_W'(1);
    localparam logic [GLITCH_W-1:0] LP_GMAX = '1;
    localparam logic [GLITCH_W-1:0] LP_G1   = GLITCH_W'(1);

    logic                w_s;
    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic                r_dout, w_dout;
    logic                r_rise, w_rise;
    logic                r_fall, w_fall;
    logic [GLITCH_W-1:0] r_gcnt, w_gcnt;
    logic                w_glitch;

    itrx_aib_phy_bit_sync #(
        .NUM_FLOPS (NUM_FLOPS)
    ) u_sync (
        .clk   (clk),
        .rst_n (~rst),
        .i_d   (din),
        .o_q   (w_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LO;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_gcnt  <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_dout  <= w_dout;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
            r_gcnt  <= w_gcnt;
        end
    end

    // The stable-state sample counts as the first of the DEBOUNCE_CYCLES run.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_dout   = r_dout;
        w_rise   = 1'b0;
        w_fall   = 1'b0;
        w_glitch = 1'b0;
        case (r_state)
            ST_LO: begin
                if (w_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state = ST_HI;
                        w_dout  = 1'b1;
                        w_rise  = 1'b1;
                    end else begin
                        w_state = CHK_HI;
                        w_cnt   = LP_ONE;
                    end
                end
            end
            CHK_HI: begin
                if (w_s) begin
                    if (r_cnt == LP_LAST) begin
                        w_state = ST_HI;
                        w_dout  = 1'b1;
                        w_rise  = 1'b1;
                    end else begin
                        w_cnt = r_cnt + LP_ONE;
                    end
                end else begin
                    w_state  = ST_LO;
                    w_glitch = 1'b1;
                end
            end
            ST_HI: begin
                if (!w_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state = ST_LO;
                        w_dout  = 1'b0;
                        w_fall  = 1'b1;
                    end else begin
                        w_state = CHK_LO;
                        w_cnt   = LP_ONE;
                    end
                end
            end
            CHK_LO: begin
                if (!w_s) begin
                    if (r_cnt == LP_LAST) begin
                        w_state = ST_LO;
                        w_dout  = 1'b0;
                        w_fall  = 1'b1;
                    end else begin
                        w_cnt = r_cnt + LP_ONE;
                    end
                end else begin
                    w_state  = ST_HI;
                    w_glitch = 1'b1;
                end
            end
            default: begin
                w_state = ST_LO;
            end
        endcase
    end

    // Clear takes effect before a same-cycle increment.
    always_comb begin
        w_gcnt = r_gcnt;
        if (w_glitch) begin
            if (glitch_clr) begin
                w_gcnt = LP_G1;
            end else if (r_gcnt != LP_GMAX) begin
                w_gcnt = r_gcnt + LP_G1;
            end
        end else if (glitch_clr) begin
            w_gcnt = '0;
        end
    end

    assign dout       = r_dout;
    assign rise_pls   = r_rise;
    assign fall_pls   = r_fall;
    assign glitch_cnt = r_gcnt;

endmodule

// File: tb/tb_itrx_aib_phy_sync_filter.sv
// Scoreboard bench: stimulus pushes expected pulses (kind, cycle); negedge monitors pop and compare.
module tb_itrx_aib_phy_sync_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic       din1 = 1'b0;
    logic       glitch_clr = 1'b0;
    logic       dout, rise_pls, fall_pls;
    logic [7:0] glitch_cnt;
    logic       dout1, rise1, fall1;
    logic [7:0] gcnt1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rise;
        int   cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    itrx_aib_phy_sync_filter #(
        .NUM_FLOPS       (2),
        .DEBOUNCE_CYCLES (8),
        .GLITCH_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .glitch_clr (glitch_clr),
        .dout       (dout),
        .rise_pls   (rise_pls),
        .fall_pls   (fall_pls),
        .glitch_cnt (glitch_cnt)
    );

    itrx_aib_phy_sync_filter #(
        .NUM_FLOPS       (2),
        .DEBOUNCE_CYCLES (1),
        .GLITCH_W        (8)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .din        (din1),
        .glitch_clr (glitch_clr),
        .dout       (dout1),
        .rise_pls   (rise1),
        .fall_pls   (fall1),
        .glitch_cnt (gcnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_pulse(input int id, input logic r, input int at);
        exp_t e;
        e.rise = r;
        e.cyc  = at;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rise_pls || fall_pls) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_unexpected_pulse: rise=%0b fall=%0b at cycle %0d, none expected",
                         rise_pls, fall_pls, cyc);
            end else begin
                e = q0.pop_front();
                check("dut0_pulse_kind", {rise_pls, fall_pls}, e.rise ? 2 : 1);
                check("dut0_pulse_cycle", cyc, e.cyc);
                check("dut0_pulse_dout", dout, e.rise);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rise1 || fall1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_pulse: rise=%0b fall=%0b at cycle %0d, none expected",
                         rise1, fall1, cyc);
            end else begin
                e = q1.pop_front();
                check("dut1_pulse_kind", {rise1, fall1}, e.rise ? 2 : 1);
                check("dut1_pulse_cycle", cyc, e.cyc);
                check("dut1_pulse_dout", dout1, e.rise);
            end
        end
    end

    initial begin
        int c;
        // Reset state, then release with din held high.
        tick(2);
        check("rst_dout", dout, 0);
        check("rst_rise", rise_pls, 0);
        check("rst_fall", fall_pls, 0);
        check("rst_gcnt", glitch_cnt, 0);
        check("rst_dout1", dout1, 0);
        rst = 1'b0;
        c = cyc;
        exp_pulse(0, 1'b1, c + 10);
        tick(9);
        check("steady_hi_pre_commit_dout", dout, 0);
        tick(2);
        check("steady_hi_rise_width", rise_pls, 0);
        check("steady_hi_dout", dout, 1);
        check("steady_hi_gcnt", glitch_cnt, 0);

        // Falling commit.
        din = 1'b0;
        c = cyc;
        exp_pulse(0, 1'b0, c + 10);
        tick(9);
        check("fall_pre_commit_dout", dout, 1);
        tick(3);
        check("fall_dout", dout, 0);
        check("fall_width", fall_pls, 0);

        // Short glitch of 3 samples.
        din = 1'b1;
        tick(3);
        din = 1'b0;
        tick(8);
        check("short_glitch_gcnt", glitch_cnt, 1);
        check("short_glitch_dout", dout, 0);

        // DEBOUNCE_CYCLES-1 samples: rejected.
        din = 1'b1;
        tick(7);
        din = 1'b0;
        tick(8);
        check("dc_minus1_gcnt", glitch_cnt, 2);
        check("dc_minus1_dout", dout, 0);

        // Exactly DEBOUNCE_CYCLES samples: commits, then falls back.
        din = 1'b1;
        c = cyc;
        exp_pulse(0, 1'b1, c + 10);
        tick(8);
        din = 1'b0;
        exp_pulse(0, 1'b0, c + 18);
        tick(12);
        check("dc_exact_dout", dout, 0);
        check("dc_exact_gcnt", glitch_cnt, 2);

        // Glitch storm: saturation.
        repeat (300) begin
            din = 1'b1;
            tick(1);
            din = 1'b0;
            tick(1);
        end
        tick(4);
        check("storm_saturate", glitch_cnt, 255);

        // Clear coincident with a glitch event.
        din = 1'b1;
        tick(1);
        din = 1'b0;
        tick(2);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        check("clr_with_glitch", glitch_cnt, 1);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        check("clr_alone", glitch_cnt, 0);

        // Reset while CHK_HI with cnt=5.
        din = 1'b1;
        tick(1);
        din = 1'b0;
        tick(4);
        check("pre_rst_gcnt", glitch_cnt, 1);
        din = 1'b1;
        tick(7);
        rst = 1'b1;
        din = 1'b0;
        #1;
        check("midchk_rst_dout", dout, 0);
        check("midchk_rst_rise", rise_pls, 0);
        check("midchk_rst_fall", fall_pls, 0);
        check("midchk_rst_gcnt", glitch_cnt, 0);
        tick(2);
        rst = 1'b0;
        tick(15);
        check("post_rst_dout", dout, 0);
        check("post_rst_gcnt", glitch_cnt, 0);

        // DEBOUNCE_CYCLES=1 instance.
        din1 = 1'b1;
        c = cyc;
        exp_pulse(1, 1'b1, c + 3);
        tick(3);
        din1 = 1'b0;
        exp_pulse(1, 1'b0, c + 6);
        tick(5);
        din1 = 1'b1;
        c = cyc;
        exp_pulse(1, 1'b1, c + 3);
        tick(1);
        din1 = 1'b0;
        exp_pulse(1, 1'b0, c + 4);
        tick(5);
        check("dc1_gcnt", gcnt1, 0);
        check("dc1_dout", dout1, 0);

        tick(3);
        check("dut0_queue_empty", q0.size(), 0);
        check("dut1_queue_empty", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
